// File: rtl/muldiv_ctrl.sv
// Iterative mult/div unit with HI/LO registers and pipeline stall control.
// Ports: clk/rst, EX-stage decode + operands in; stall, busy, hilo_we, Hi_out, Lo_out out.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  op_ex,
  input  logic [5:0]  func_ex,
  input  logic [31:0] busA_ex,
  input  logic [31:0] busB_ex,
  input  logic        xiaoc_ex,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] hi_acc;
  logic [31:0] lo_acc;
  logic [31:0] opb;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div0;

  logic is_r;
  logic d_mult, d_multu, d_div, d_divu;
  logic d_mthi, d_mtlo, d_mf;
  logic d_iter, d_any;
  logic live, go, mt_ok;

  assign is_r    = (op_ex == 6'b000000);
  assign d_mult  = is_r & (func_ex == F_MULT);
  assign d_multu = is_r & (func_ex == F_MULTU);
  assign d_div   = is_r & (func_ex == F_DIV);
  assign d_divu  = is_r & (func_ex == F_DIVU);
  assign d_mthi  = is_r & (func_ex == F_MTHI);
  assign d_mtlo  = is_r & (func_ex == F_MTLO);
  assign d_mf    = is_r & ((func_ex == F_MFHI) | (func_ex == F_MFLO));
  assign d_iter  = d_mult | d_multu | d_div | d_divu;
  assign d_any   = d_iter | d_mthi | d_mtlo | d_mf;

  assign live  = start & ~xiaoc_ex;
  assign go    = live & ~busy & d_iter;
  assign mt_ok = live & ~busy & (d_mthi | d_mtlo);

  // rst gates stall so a frozen pipeline is released during reset
  assign stall = ~rst & busy & live & d_any;

  // Operand conditioning: magnitudes for signed ops
  logic        sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_abs, b_abs;

  assign sgn   = d_mult | d_div;
  assign a_neg = sgn & busA_ex[31];
  assign b_neg = sgn & busB_ex[31];
  assign a_abs = a_neg ? -busA_ex : busA_ex;
  assign b_abs = b_neg ? -busB_ex : busB_ex;

  // Multiply step: {hi_acc, lo_acc} shifts right, lo_acc holds multiplier
  logic [32:0] m_sum;
  assign m_sum = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opb} : 33'd0);

  // Restoring divide step: hi_acc = partial remainder, lo_acc = dividend/quotient
  logic [32:0] d_sh;
  logic [32:0] d_diff;
  logic        d_ok;
  assign d_sh   = {hi_acc, lo_acc[31]};
  assign d_diff = d_sh - {1'b0, opb};
  assign d_ok   = ~d_diff[32];

  // Sign correction
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  assign prod     = {hi_acc, lo_acc};
  assign prod_fix = neg_res ? -prod : prod;
  assign quo_fix  = div0 ? 32'hFFFF_FFFF : (neg_res ? -lo_acc : lo_acc);
  // For a zero divisor the remainder is |dividend|, so this restores busA_ex
  assign rem_fix  = neg_rem ? -hi_acc : hi_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 5'd0;
      busy    <= 1'b0;
      hilo_we <= 1'b0;
      Hi_out  <= 32'd0;
      Lo_out  <= 32'd0;
      hi_acc  <= 32'd0;
      lo_acc  <= 32'd0;
      opb     <= 32'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else begin
      hilo_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            cnt     <= 5'd31;
            hi_acc  <= 32'd0;
            is_div  <= d_div | d_divu;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            div0    <= (d_div | d_divu) & (busB_ex == 32'd0);
            if (d_div | d_divu) begin
              lo_acc <= a_abs;
              opb    <= b_abs;
            end else begin
              lo_acc <= b_abs;
              opb    <= a_abs;
            end
          end else if (mt_ok) begin
            hilo_we <= 1'b1;
            if (d_mthi) Hi_out <= busA_ex;
            if (d_mtlo) Lo_out <= busA_ex;
          end
        end
        S_RUN: begin
          if (is_div) begin
            hi_acc <= d_ok ? d_diff[31:0] : d_sh[31:0];
            lo_acc <= {lo_acc[30:0], d_ok};
          end else begin
            hi_acc <= m_sum[32:1];
            lo_acc <= {m_sum[0], lo_acc[31:1]};
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= S_FIX;
        end
        S_FIX: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          hilo_we <= 1'b1;
          if (is_div) begin
            Lo_out <= quo_fix;
            Hi_out <= rem_fix;
          end else begin
            Hi_out <= prod_fix[63:32];
            Lo_out <= prod_fix[31:0];
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
